// File: rtl/memory_pkg.sv
// Shared encodings for the L1 caches, the arbiter and the memory controller.
package memory_pkg;

  // Default width of address and data buses.
  localparam int unsigned DefaultDataWidth = 32;

  // Width of the BUSY watchdog counter.
  localparam int unsigned TimeoutCountWidth = 8;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StBusy    = 2'd1,
    StRespond = 2'd2
  } arb_state_e;

  // Requester identity, also used as the round-robin history bit.
  typedef enum logic {
    OwnerInst = 1'b0,
    OwnerData = 1'b1
  } owner_e;

endpackage

// File: rtl/round_robin_picker.sv
// Combinational two-input round-robin picker: on a tie the requester that was
// not served last wins.
module round_robin_picker
  import memory_pkg::*;
(
  input  logic inst_request,
  input  logic data_request,
  input  logic last_owner,
  output logic grant_valid,
  output logic grant_owner
);

  // Pick a winner from the live requests and the last-served owner.
  always_comb begin
    grant_valid = inst_request | data_request;
    grant_owner = OwnerInst;
    if (inst_request && data_request) begin
      grant_owner = (last_owner == OwnerInst) ? OwnerData : OwnerInst;
    end else if (data_request) begin
      grant_owner = OwnerData;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Shares one memory controller between the instruction and data L1 caches.
// One transfer at a time: IDLE arbitrates, BUSY holds the latched transfer
// toward the controller, RESPOND returns a one-cycle ready pulse to the owner.
// A watchdog aborts transfers the controller never completes.
module memory_arbiter
  import memory_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DefaultDataWidth,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  inst_request,
  input  logic [DATA_WIDTH-1:0] inst_address,
  output logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst_data,
  input  logic                  data_request,
  input  logic [DATA_WIDTH-1:0] data_address,
  input  logic                  data_write,
  input  logic [DATA_WIDTH-1:0] data_wdata,
  output logic                  data_ready,
  output logic [DATA_WIDTH-1:0] data_rdata,
  output logic                  mem_request,
  output logic [DATA_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_write,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ready,
  output logic                  timeout
);

  localparam logic [TimeoutCountWidth-1:0] TimeoutLimit = TIMEOUT_CYCLES[TimeoutCountWidth-1:0];

  arb_state_e                   state_q, state_d;
  owner_e                       owner_q, owner_d;
  owner_e                       last_owner_q, last_owner_d;
  logic [DATA_WIDTH-1:0]        address_q, address_d;
  logic [DATA_WIDTH-1:0]        wdata_q, wdata_d;
  logic                         write_q, write_d;
  logic [DATA_WIDTH-1:0]        rdata_q, rdata_d;
  logic [TimeoutCountWidth-1:0] count_q, count_d;
  logic                         inst_ready_q, inst_ready_d;
  logic                         data_ready_q, data_ready_d;
  logic                         timeout_q, timeout_d;

  logic                         grant_valid;
  logic                         grant_owner;
  logic [TimeoutCountWidth-1:0] count_inc;

  round_robin_picker u_picker (
    .inst_request (inst_request),
    .data_request (data_request),
    .last_owner   (last_owner_q),
    .grant_valid  (grant_valid),
    .grant_owner  (grant_owner)
  );

  assign count_inc = count_q + 1'b1;

  // Next-state logic: arbitration, transfer tracking, watchdog and response.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    address_d    = address_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    rdata_d      = rdata_q;
    count_d      = count_q;
    inst_ready_d = 1'b0;
    data_ready_d = 1'b0;
    timeout_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          owner_d = owner_e'(grant_owner);
          if (grant_owner == OwnerData) begin
            address_d = data_address;
            write_d   = data_write;
            wdata_d   = data_wdata;
          end else begin
            // Instruction side is read-only.
            address_d = inst_address;
            write_d   = 1'b0;
            wdata_d   = '0;
          end
          count_d = '0;
          state_d = StBusy;
        end
      end

      StBusy: begin
        // Completion beats the watchdog when both land on the same edge.
        if (mem_ready) begin
          rdata_d      = mem_rdata;
          inst_ready_d = (owner_q == OwnerInst);
          data_ready_d = (owner_q == OwnerData);
          state_d      = StRespond;
        end else if (count_inc == TimeoutLimit) begin
          rdata_d      = '0;
          timeout_d    = 1'b1;
          inst_ready_d = (owner_q == OwnerInst);
          data_ready_d = (owner_q == OwnerData);
          state_d      = StRespond;
        end else begin
          count_d = count_inc;
        end
      end

      StRespond: begin
        last_owner_d = owner_q;
        state_d      = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      owner_q      <= OwnerInst;
      last_owner_q <= OwnerInst;
      address_q    <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
      rdata_q      <= '0;
      count_q      <= '0;
      inst_ready_q <= 1'b0;
      data_ready_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      address_q    <= address_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
      rdata_q      <= rdata_d;
      count_q      <= count_d;
      inst_ready_q <= inst_ready_d;
      data_ready_q <= data_ready_d;
      timeout_q    <= timeout_d;
    end
  end

  // Controller side sees the latched transfer only while BUSY.
  always_comb begin
    mem_request = (state_q == StBusy);
    mem_write   = write_q & (state_q == StBusy);
    mem_address = address_q;
    mem_wdata   = wdata_q;
  end

  // Cache side: registered one-cycle pulses with the latched read data.
  always_comb begin
    inst_ready = inst_ready_q;
    data_ready = data_ready_q;
    timeout    = timeout_q;
    inst_data  = rdata_q;
    data_rdata = rdata_q;
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios followed by
// randomized transactions against a transaction-level reference model.
module tb_memory_arbiter;

  localparam int unsigned Width = 32;
  localparam int          Limit = 4;

  logic             clock;
  logic             reset_n;
  logic             inst_request;
  logic [Width-1:0] inst_address;
  logic             inst_ready;
  logic [Width-1:0] inst_data;
  logic             data_request;
  logic [Width-1:0] data_address;
  logic             data_write;
  logic [Width-1:0] data_wdata;
  logic             data_ready;
  logic [Width-1:0] data_rdata;
  logic             mem_request;
  logic [Width-1:0] mem_address;
  logic [Width-1:0] mem_wdata;
  logic             mem_write;
  logic [Width-1:0] mem_rdata;
  logic             mem_ready;
  logic             timeout;

  int checks;
  int failures;
  bit last_owner_m;  // 0 = instruction served last, 1 = data

  memory_arbiter #(
    .DATA_WIDTH     (Width),
    .TIMEOUT_CYCLES (Limit)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .inst_request (inst_request),
    .inst_address (inst_address),
    .inst_ready   (inst_ready),
    .inst_data    (inst_data),
    .data_request (data_request),
    .data_address (data_address),
    .data_write   (data_write),
    .data_wdata   (data_wdata),
    .data_ready   (data_ready),
    .data_rdata   (data_rdata),
    .mem_request  (mem_request),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_write    (mem_write),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready),
    .timeout      (timeout)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Outputs expected whenever no transfer and no response is in flight.
  task automatic check_quiet(input string tag);
    check({tag, ".mem_request"}, mem_request, 0);
    check({tag, ".mem_write"}, mem_write, 0);
    check({tag, ".inst_ready"}, inst_ready, 0);
    check({tag, ".data_ready"}, data_ready, 0);
    check({tag, ".timeout"}, timeout, 0);
  endtask

  // One full transaction, entered and left at a negedge in IDLE.
  // rdy_k: BUSY cycle (1-based) on which mem_ready is raised; 0 or > Limit = never.
  task automatic txn(input string tag, input bit ireq, input bit dreq,
                     input logic [31:0] iaddr, input logic [31:0] daddr, input bit dwr,
                     input logic [31:0] dwd, input int rdy_k, input logic [31:0] rd);
    bit          exp_owner;
    bit          exp_to;
    int          end_k;
    logic [31:0] exp_addr;
    logic [31:0] exp_wd;
    bit          exp_wr;
    logic [31:0] exp_rd;

    exp_owner = (ireq && dreq) ? ~last_owner_m : dreq;
    exp_addr  = exp_owner ? daddr : iaddr;
    exp_wd    = exp_owner ? dwd : 32'h0;
    exp_wr    = exp_owner ? dwr : 1'b0;
    exp_to    = (rdy_k < 1) || (rdy_k > Limit);
    end_k     = exp_to ? Limit : rdy_k;
    exp_rd    = exp_to ? 32'h0 : rd;

    inst_request = ireq;
    inst_address = iaddr;
    data_request = dreq;
    data_address = daddr;
    data_write   = dwr;
    data_wdata   = dwd;
    @(posedge clock);
    for (int k = 1; k <= end_k; k++) begin
      @(negedge clock);
      check({tag, ".busy.mem_request"}, mem_request, 1);
      check({tag, ".busy.mem_address"}, mem_address, exp_addr);
      check({tag, ".busy.mem_write"}, mem_write, exp_wr);
      check({tag, ".busy.mem_wdata"}, mem_wdata, exp_wd);
      check({tag, ".busy.inst_ready"}, inst_ready, 0);
      check({tag, ".busy.data_ready"}, data_ready, 0);
      // Fields wiggling during BUSY must not reach the controller.
      inst_address = $urandom;
      data_address = $urandom;
      data_wdata   = $urandom;
      data_write   = 1'($urandom);
      mem_ready    = (k == rdy_k);
      mem_rdata    = (k == rdy_k) ? rd : $urandom;
      @(posedge clock);
    end
    @(negedge clock);
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    check({tag, ".resp.inst_ready"}, inst_ready, !exp_owner);
    check({tag, ".resp.data_ready"}, data_ready, exp_owner);
    check({tag, ".resp.timeout"}, timeout, exp_to);
    check({tag, ".resp.mem_request"}, mem_request, 0);
    if (exp_owner) begin
      check({tag, ".resp.data_rdata"}, data_rdata, exp_rd);
      data_request = 1'b0;
    end else begin
      check({tag, ".resp.inst_data"}, inst_data, exp_rd);
      inst_request = 1'b0;
    end
    last_owner_m = exp_owner;
    @(posedge clock);
    @(negedge clock);
    check_quiet({tag, ".dead"});
  endtask

  initial begin
    int unsigned r;
    int          k;

    checks       = 0;
    failures     = 0;
    last_owner_m = 1'b0;
    reset_n      = 1'b1;
    inst_request = 1'b0;
    inst_address = '0;
    data_request = 1'b0;
    data_address = '0;
    data_write   = 1'b0;
    data_wdata   = '0;
    mem_rdata    = '0;
    mem_ready    = 1'b0;
    #1 reset_n = 1'b0;

    // Reset state.
    @(negedge clock);
    @(negedge clock);
    check_quiet("reset");
    check("reset.mem_address", mem_address, 0);
    check("reset.mem_wdata", mem_wdata, 0);
    check("reset.inst_data", inst_data, 0);
    check("reset.data_rdata", data_rdata, 0);
    reset_n = 1'b1;
    @(negedge clock);
    check_quiet("idle0");

    // Minimum-latency instruction read.
    txn("inst_read", 1, 0, 32'h100, 32'h0, 0, 32'h0, 1, 32'hDEADBEEF);

    // mem_ready outside BUSY is ignored.
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b1;
      mem_rdata = $urandom;
      @(negedge clock);
      check_quiet("stray_ready");
    end
    mem_ready = 1'b0;

    // Continuous pair alternates starting with data.
    for (int i = 0; i < 4; i++) begin
      txn("pair", 1, 1, 32'h400 + i, 32'h800 + i, 0, 32'h0, 2, 32'hA000_0000 + i);
    end

    // Data write.
    txn("write", 0, 1, 32'h0, 32'h2000, 1, 32'h12345678, 3, 32'h0BAD_F00D);

    // Watchdog abort, then a normal request.
    txn("abort", 0, 1, 32'h0, 32'h3000, 0, 32'h0, 0, 32'h0);
    txn("after_abort", 1, 0, 32'h140, 32'h0, 0, 32'h0, 2, 32'h5555_AAAA);

    // Completion on the limit cycle wins.
    txn("at_limit", 0, 1, 32'h0, 32'h3100, 0, 32'h0, Limit, 32'hCAFE_0001);

    // Reset mid-BUSY.
    inst_request = 1'b1;
    inst_address = 32'h180;
    @(posedge clock);
    @(negedge clock);
    check("rst_busy.mem_request_before", mem_request, 1);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    check_quiet("rst_busy.async");
    @(negedge clock);
    inst_request = 1'b0;
    reset_n      = 1'b1;
    last_owner_m = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check_quiet("rst_busy.after");
    txn("rst_fresh", 1, 0, 32'h1C0, 32'h0, 0, 32'h0, 1, 32'h7777_0000);
    txn("rst_tie", 1, 1, 32'h200, 32'h240, 0, 32'h0, 1, 32'h7777_0001);

    // Randomized transactions.
    for (int n = 0; n < 24; n++) begin
      r = $urandom_range(1, 3);
      k = $urandom_range(0, Limit + 2);
      txn("rand", r[0], r[1], $urandom, $urandom, 1'($urandom), $urandom, k, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
